fp_add_sub: RTL and testbench
=============================

// Module: fp_add_sub
// PURPOSE
//  Pipelined IEEE-754 single-precision floating-point adder/subtractor for the
//  EX-stage FPU (alu_F fadd/fsub). Computes dataa + datab or dataa - datab.
//  Fully pipelined: accepts one operation per clock; result emerges after a fixed
//  7-cycle latency, matching the stall_counter latency of 7 programmed for fadd.
// PARAMETERS
//  none configurable; localparam LATENCY = 7 (clocks from input sample to result)
// PORTS
//  clock    in   1   system clock, all state updates on rising edge
//  rst_n    in   1   asynchronous active-low reset; clears entire pipeline
//  add_sub  in   1   operation select: 0 = add, 1 = subtract (dataa - datab)
//  dataa    in   32  operand A, IEEE-754 binary32
//  datab    in   32  operand B, IEEE-754 binary32
//  result   out  32  registered IEEE-754 binary32 result
// BEHAVIOUR
//  - One clock; rst_n asynchronous, active-low. While rst_n=0: every pipeline
//    register and result = 32'h0000_0000. After release, result stays 0 until
//    the first post-reset operation reaches the output; no in-flight op survives.
//  - No valid/handshake: inputs sampled every rising edge; result at edge N+7
//    reflects the operands/add_sub sampled at edge N. Back-to-back ops independent.
//  - Stages: S1 register inputs, unpack, flip B sign if add_sub=1, classify
//    specials; S2 compare exponents/magnitudes, swap so |X|>=|Y|, exp diff;
//    S3 align smaller mantissa right (guard, round, sticky; diff>=26 -> sticky
//    only); S4 28-bit mantissa add or subtract by effective operation;
//    S5 leading-zero count / carry detect; S6 normalize shift, adjust exponent;
//    S7 round-to-nearest-even, handle mantissa overflow on rounding, pack, register.
//  - Rounding: RNE only; ties go to even mantissa LSB.
//  - Denormals: input denormals flushed to signed zero; results below min normal
//    (exp <= 0) flushed to signed zero. No denormal outputs.
//  - Overflow: biased exponent >= 255 after rounding -> signed infinity.
//  - Zeros: exact-zero result of x-x -> +0 (32'h0000_0000); (-0)+(-0) -> -0;
//    (+0)+(-0) -> +0; x+0 -> x (normalized x unchanged).
//  - NaN/Inf: any NaN input -> canonical quiet NaN 32'h7FC0_0000;
//    inf + inf same sign -> that inf; inf - inf (effective) -> 32'h7FC0_0000;
//    inf +/- finite -> the inf with its effective sign.
//  - Special-case result carried down the pipe with a bypass flag so it still
//    appears with exactly 7-cycle latency.
//  - No exception flag outputs.
// TESTING
//  - 3F800000 + 40000000, add_sub=0 -> 40400000 exactly 7 clocks later; result
//    stays 0 for all earlier post-reset cycles.
//  - 3F800000 - 3F800000 (add_sub=1) -> 00000000; C0000000 - 3F800000 -> C0400000.
//  - Stream: cycle0 3FC00000+3FC00000, cycle1 40400000-3F800000 -> 40400000 then
//    40000000 on consecutive cycles 7 and 8.
//  - Rounding: 3F800000 + 33800000 -> 3F800000 (tie to even); 3F800001 +
//    33800000 -> 3F800002; 7F7FFFFF + 7F7FFFFF -> 7F800000.
//  - Specials: 7F800000 - 7F800000 (add_sub=1) -> 7FC00000; 7F800000 + 3F800000
//    -> 7F800000; 7FC00001 + 3F800000 -> 7FC00000; 00000001 + 00000000 -> 00000000.
//  - Reset mid-operation: issue 4 ops, drop rst_n low for 1 cycle at cycle 3 ->
//    result 0 immediately (async); none of the 4 results ever appears afterwards.

Source files
------------

// File: rtl/fp_add_sub.sv
// Seven-stage pipelined IEEE-754 binary32 adder/subtractor (RNE, flush-to-zero).
// Special operands bypass the datapath but travel alongside it so latency is fixed.
module fp_add_sub (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        add_sub,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result
);

  localparam int          LATENCY = 7;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  logic [31:0] in_a, in_b;
  logic        in_op;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      in_a  <= '0;
      in_b  <= '0;
      in_op <= 1'b0;
    end else begin
      in_a  <= dataa;
      in_b  <= datab;
      in_op <= add_sub;
    end
  end

  // ---------------- S1: unpack, effective sign of B, classify ----------------
  logic       a_sign, b_sign;
  logic [7:0] a_exp, b_exp;
  logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic       byp_d;
  logic [31:0] val_d;

  always_comb begin
    a_sign = in_a[31];
    b_sign = in_b[31] ^ in_op;
    a_exp  = in_a[30:23];
    b_exp  = in_b[30:23];
    a_nan  = (a_exp == 8'hFF) && (in_a[22:0] != 23'd0);
    b_nan  = (b_exp == 8'hFF) && (in_b[22:0] != 23'd0);
    a_inf  = (a_exp == 8'hFF) && (in_a[22:0] == 23'd0);
    b_inf  = (b_exp == 8'hFF) && (in_b[22:0] == 23'd0);
    a_zero = (a_exp == 8'h00);
    b_zero = (b_exp == 8'h00);
    byp_d  = 1'b1;
    val_d  = '0;
    if (a_nan || b_nan)
      val_d = QNAN;
    else if (a_inf && b_inf)
      val_d = (a_sign == b_sign) ? {a_sign, 8'hFF, 23'd0} : QNAN;
    else if (a_inf)
      val_d = {a_sign, 8'hFF, 23'd0};
    else if (b_inf)
      val_d = {b_sign, 8'hFF, 23'd0};
    else if (a_zero && b_zero)
      val_d = {a_sign & b_sign, 31'd0};
    else if (b_zero)
      val_d = {a_sign, in_a[30:0]};
    else if (a_zero)
      val_d = {b_sign, in_b[30:0]};
    else
      byp_d = 1'b0;
  end

  // Bypass flag/value delay line, aligned so its tail meets the S7 output register
  logic [LATENCY-2:0] byp_pipe;
  logic [31:0]        val_pipe [LATENCY-1];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      byp_pipe <= '0;
      for (int i = 0; i < LATENCY - 1; i++) val_pipe[i] <= '0;
    end else begin
      byp_pipe    <= {byp_pipe[LATENCY-3:0], byp_d};
      val_pipe[0] <= val_d;
      for (int i = 1; i < LATENCY - 1; i++) val_pipe[i] <= val_pipe[i-1];
    end
  end

  logic        s1_sa, s1_sb;
  logic [7:0]  s1_ea, s1_eb;
  logic [23:0] s1_ma, s1_mb;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_sa <= 1'b0;
      s1_sb <= 1'b0;
      s1_ea <= '0;
      s1_eb <= '0;
      s1_ma <= '0;
      s1_mb <= '0;
    end else begin
      s1_sa <= a_sign;
      s1_sb <= b_sign;
      s1_ea <= a_exp;
      s1_eb <= b_exp;
      s1_ma <= {1'b1, in_a[22:0]};
      s1_mb <= {1'b1, in_b[22:0]};
    end
  end

  // ---------------- S2: order operands so |X| >= |Y| ----------------
  logic a_ge;
  assign a_ge = {s1_ea, s1_ma} >= {s1_eb, s1_mb};

  logic        s2_sign, s2_sub;
  logic [7:0]  s2_exp, s2_diff;
  logic [23:0] s2_mx, s2_my;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s2_sign <= 1'b0;
      s2_sub  <= 1'b0;
      s2_exp  <= '0;
      s2_diff <= '0;
      s2_mx   <= '0;
      s2_my   <= '0;
    end else begin
      s2_sign <= a_ge ? s1_sa : s1_sb;
      s2_sub  <= s1_sa ^ s1_sb;
      s2_exp  <= a_ge ? s1_ea : s1_eb;
      s2_diff <= a_ge ? (s1_ea - s1_eb) : (s1_eb - s1_ea);
      s2_mx   <= a_ge ? s1_ma : s1_mb;
      s2_my   <= a_ge ? s1_mb : s1_ma;
    end
  end

  // ---------------- S3: align Y, keeping guard/round/sticky ----------------
  logic [26:0] y_ext, y_sh, y_lost, y_al;

  always_comb begin
    y_ext  = {s2_my, 3'b000};
    y_sh   = y_ext >> s2_diff[4:0];
    y_lost = y_ext & ~({27{1'b1}} << s2_diff[4:0]);
    if (s2_diff >= 8'd26)
      y_al = {26'd0, 1'b1};
    else
      y_al = {y_sh[26:1], y_sh[0] | (|y_lost)};
  end

  logic        s3_sign, s3_sub;
  logic [7:0]  s3_exp;
  logic [26:0] s3_x, s3_y;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s3_sign <= 1'b0;
      s3_sub  <= 1'b0;
      s3_exp  <= '0;
      s3_x    <= '0;
      s3_y    <= '0;
    end else begin
      s3_sign <= s2_sign;
      s3_sub  <= s2_sub;
      s3_exp  <= s2_exp;
      s3_x    <= {s2_mx, 3'b000};
      s3_y    <= y_al;
    end
  end

  // ---------------- S4: 28-bit magnitude add/subtract ----------------
  logic        s4_sign;
  logic [7:0]  s4_exp;
  logic [27:0] s4_sum;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s4_sign <= 1'b0;
      s4_exp  <= '0;
      s4_sum  <= '0;
    end else begin
      s4_sign <= s3_sign;
      s4_exp  <= s3_exp;
      s4_sum  <= s3_sub ? ({1'b0, s3_x} - {1'b0, s3_y})
                        : ({1'b0, s3_x} + {1'b0, s3_y});
    end
  end

  // ---------------- S5: leading-zero count and carry detect ----------------
  logic [4:0] lzc_d;
  logic       found;

  always_comb begin
    lzc_d = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (s4_sum[i]) found = 1'b1;
        else           lzc_d = lzc_d + 5'd1;
      end
    end
  end

  logic        s5_sign, s5_carry, s5_zero;
  logic [7:0]  s5_exp;
  logic [4:0]  s5_lzc;
  logic [27:0] s5_sum;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s5_sign  <= 1'b0;
      s5_carry <= 1'b0;
      s5_zero  <= 1'b0;
      s5_exp   <= '0;
      s5_lzc   <= '0;
      s5_sum   <= '0;
    end else begin
      s5_sign  <= s4_sign;
      s5_carry <= s4_sum[27];
      s5_zero  <= (s4_sum == 28'd0);
      s5_exp   <= s4_exp;
      s5_lzc   <= lzc_d;
      s5_sum   <= s4_sum;
    end
  end

  // ---------------- S6: normalize and adjust exponent ----------------
  logic        s6_sign, s6_zero;
  logic [26:0] s6_norm;
  logic signed [9:0] s6_exp;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s6_sign <= 1'b0;
      s6_zero <= 1'b0;
      s6_norm <= '0;
      s6_exp  <= '0;
    end else begin
      s6_sign <= s5_sign;
      s6_zero <= s5_zero;
      if (s5_carry) begin
        s6_norm <= {s5_sum[27:2], s5_sum[1] | s5_sum[0]};
        s6_exp  <= $signed({2'b00, s5_exp}) + 10'sd1;
      end else begin
        s6_norm <= s5_sum[26:0] << s5_lzc;
        s6_exp  <= $signed({2'b00, s5_exp}) - $signed({5'd0, s5_lzc});
      end
    end
  end

  // ---------------- S7: round to nearest even, range check, pack ----------------
  logic              round_up;
  logic [24:0]       rnd;
  logic signed [9:0] e7;
  logic [22:0]       frac7;
  logic [31:0]       packed_d;

  always_comb begin
    round_up = s6_norm[2] & (s6_norm[1] | s6_norm[0] | s6_norm[3]);
    rnd      = {1'b0, s6_norm[26:3]} + {24'd0, round_up};
    e7       = s6_exp + $signed({9'd0, rnd[24]});
    frac7    = rnd[24] ? rnd[23:1] : rnd[22:0];
    if (s6_zero)
      packed_d = 32'h0000_0000;
    else if (e7 <= 10'sd0)
      packed_d = {s6_sign, 31'd0};
    else if (e7 >= 10'sd255)
      packed_d = {s6_sign, 8'hFF, 23'd0};
    else
      packed_d = {s6_sign, e7[7:0], frac7};
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)
      result <= '0;
    else
      result <= byp_pipe[LATENCY-2] ? val_pipe[LATENCY-2] : packed_d;
  end

endmodule

// File: tb/tb_fp_add_sub.sv
// Scoreboard bench for fp_add_sub: every issued cycle pushes its expected result,
// a negedge monitor pops and compares when that result is due.
module tb_fp_add_sub;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        add_sub = 1'b0;
  logic [31:0] dataa = '0;
  logic [31:0] datab = '0;
  logic [31:0] result;

  fp_add_sub dut (
    .clock   (clock),
    .rst_n   (rst_n),
    .add_sub (add_sub),
    .dataa   (dataa),
    .datab   (datab),
    .result  (result)
  );

  always #5 clock = ~clock;

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [31:0] expv;
    int          due;
    string       name;
  } item_t;

  item_t sb_q[$];
  int    tests_run    = 0;
  int    tests_failed = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s: result=%08h expected=%08h (edge %0d)", name, act, expv, edge_cnt);
    end
  endtask

  // Monitor: compare whatever result is due at the edge just passed
  always @(negedge clock) begin : monitor
    item_t it;
    while (sb_q.size() > 0 && sb_q[0].due <= edge_cnt) begin
      it = sb_q.pop_front();
      if (it.due != edge_cnt) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: missed due edge %0d at edge %0d", it.name, it.due, edge_cnt);
      end else begin
        checkOutput(it.name, result, it.expv);
      end
    end
  end

  // Called at a negedge: drive one op, expect it 7 edges after its sampling edge
  task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic op, input logic [31:0] expv);
    item_t it;
    dataa   = a;
    datab   = b;
    add_sub = op;
    it.expv = expv;
    it.due  = edge_cnt + 8;
    it.name = name;
    sb_q.push_back(it);
    @(negedge clock);
  endtask

  task automatic expectQuiet(input int n);
    item_t it;
    for (int i = 1; i <= n; i++) begin
      it.expv = 32'h0;
      it.due  = edge_cnt + i;
      it.name = "quiet";
      sb_q.push_back(it);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus("idle", 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin : timeout
    #1000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    item_t it;
    int    guard;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_state", result, 32'h0);
    rst_n = 1'b1;

    expectQuiet(7);
    applyStimulus("add_1_2", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000);
    applyStimulus("sub_x_x", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000);
    applyStimulus("sub_neg", 32'hC0000000, 32'h3F800000, 1'b1, 32'hC0400000);
    applyStimulus("stream0", 32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000);
    applyStimulus("stream1", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000);
    applyStimulus("rne_tie", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000);
    applyStimulus("rne_odd", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002);
    applyStimulus("ovf_inf", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000);
    applyStimulus("inf_m_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000);
    applyStimulus("inf_p_one", 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000);
    applyStimulus("nan_in", 32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000);
    applyStimulus("denorm", 32'h00000001, 32'h00000000, 1'b0, 32'h00000000);
    applyStimulus("nz_nz", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000);
    applyStimulus("pz_nz", 32'h00000000, 32'h80000000, 1'b0, 32'h00000000);
    applyStimulus("x_p_0", 32'h40490FDB, 32'h00000000, 1'b0, 32'h40490FDB);
    applyStimulus("cancel", 32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000);
    applyStimulus("underflow", 32'h00800001, 32'h00800000, 1'b1, 32'h00000000);
    applyStimulus("one_m_inf", 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000);
    applyStimulus("mixed", 32'h40000000, 32'hBF800000, 1'b0, 32'h3F800000);
    applyStimulus("ninf_ninf", 32'hFF800000, 32'hFF800000, 1'b0, 32'hFF800000);
    applyStimulus("sub_ulp", 32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF);
    applyStimulus("rnd_up", 32'h4B800000, 32'h3FC00000, 1'b0, 32'h4B800001);
    applyStimulus("sticky", 32'h4C800000, 32'h3F800000, 1'b0, 32'h4C800000);
    applyStimulus("rnd_carry", 32'h4C800000, 32'h3F800000, 1'b1, 32'h4C800000);
    idle(8);

    // Reset mid-stream: ops 0..2 complete before reset, ops 3..9 must vanish
    for (int k = 0; k < 10; k++)
      applyStimulus("rst_op", 32'h3F800000, 32'h40000000, 1'b0,
                    (k < 3) ? 32'h40400000 : 32'h00000000);
    dataa   = 32'h0;
    datab   = 32'h0;
    add_sub = 1'b0;
    it.expv = 32'h0;
    it.due  = edge_cnt + 8;
    it.name = "rst_cycle";
    sb_q.push_back(it);
    #2 rst_n = 1'b0;
    #1 checkOutput("reset_async", result, 32'h0);
    @(negedge clock);
    rst_n = 1'b1;
    idle(10);
    applyStimulus("post_rst", 32'hC0000000, 32'h3F800000, 1'b1, 32'hC0400000);
    idle(2);

    guard = 0;
    while (sb_q.size() > 0 && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL drain: pending=%0d expected=0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
